// File: rtl/pa_fpu.sv
// rtl/pa_fpu.sv - shared FPU types, host register map and byte helpers
//
// Purpose: types and constants shared by the FPU and its CPU-side host
// interface (fpu_host_if).
// Contents:
//   e_fpu_operation  4-bit opcode; op_exp is the highest legal code
//   e_fpu_host_state host interface FSM state
//   FPU_REG_*        host register byte addresses
//   FPU_STAT_*       bit positions inside the STATUS register
//   fpu_get_byte / fpu_set_byte  byte lane access into a 32-bit word
package pa_fpu;

  typedef enum logic [3:0] {
    op_add  = 4'h0,
    op_sub  = 4'h1,
    op_mul  = 4'h2,
    op_div  = 4'h3,
    op_sqrt = 4'h4,
    op_neg  = 4'h5,
    op_abs  = 4'h6,
    op_f2i  = 4'h7,
    op_i2f  = 4'h8,
    op_exp  = 4'h9
  } e_fpu_operation;

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_issue = 2'd1,
    st_wait  = 2'd2,
    st_done  = 2'd3
  } e_fpu_host_state;

  localparam logic [3:0] FPU_REG_A0     = 4'h0;
  localparam logic [3:0] FPU_REG_B0     = 4'h4;
  localparam logic [3:0] FPU_REG_CMD    = 4'h8;
  localparam logic [3:0] FPU_REG_STATUS = 4'h9;
  localparam logic [3:0] FPU_REG_RES0   = 4'hC;
  localparam logic [3:0] FPU_REG_RES3   = 4'hF;

  localparam int FPU_STAT_BUSY     = 0;
  localparam int FPU_STAT_DONE     = 1;
  localparam int FPU_STAT_TIMEOUT  = 2;
  localparam int FPU_STAT_OVERRUN  = 3;
  localparam int FPU_STAT_ILLEGAL  = 4;

  function automatic logic [7:0] fpu_get_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] fpu_set_byte(input logic [31:0] w, input logic [1:0] idx,
                                               input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fpu_host_if.sv
// rtl/fpu_host_if.sv - 8-bit CPU bus to 32-bit FPU command bridge
//
// Purpose: the CPU loads operands A/B byte-wise, writes an opcode to CMD,
// this block pulses fpu_start, waits for fpu_done (or a timeout), latches
// the result and raises irq until the result MSB byte is read.
// Ports:
//   clk, arst          clock, asynchronous active-low reset
//   cs, wr, rd, addr   CPU bus strobes and 4-bit register address
//   data_in/data_out   CPU write data / combinational read data
//   irq                level, follows the done flag
//   fpu_start          one-cycle start pulse
//   fpu_operation      opcode, stable for the whole command
//   fpu_a, fpu_b       operands, stable while busy
//   fpu_done           one-cycle completion pulse, fpu_result valid with it
module fpu_host_if
  import pa_fpu::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic           clk,
  input  logic           arst,
  input  logic           cs,
  input  logic           wr,
  input  logic           rd,
  input  logic [3:0]     addr,
  input  logic [7:0]     data_in,
  output logic [7:0]     data_out,
  output logic           irq,
  output logic           fpu_start,
  output e_fpu_operation fpu_operation,
  output logic [31:0]    fpu_a,
  output logic [31:0]    fpu_b,
  input  logic           fpu_done,
  input  logic [31:0]    fpu_result
);

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  e_fpu_host_state state_q, state_d;
  e_fpu_operation  op_q, op_d;
  logic [31:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic            done_q, done_d, illegal_q, illegal_d;
  logic            overrun_q, overrun_d, timeout_q, timeout_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic       busy, wr_en, rd_en, wr_rw_reg, cmd_wr, cmd_ok;
  logic       status_rd, msb_rd;
  logic [7:0] status;

  assign busy      = (state_q == st_issue) || (state_q == st_wait);
  assign wr_en     = cs && wr;
  assign rd_en     = cs && rd;
  // A, B and CMD are the only writable locations (0x0-0x8).
  assign wr_rw_reg = wr_en && (!addr[3] || (addr == FPU_REG_CMD));
  assign cmd_wr    = wr_en && !busy && (addr == FPU_REG_CMD);
  assign cmd_ok    = cmd_wr && (data_in[3:0] <= op_exp);
  assign status_rd = rd_en && (addr == FPU_REG_STATUS);
  assign msb_rd    = rd_en && (addr == FPU_REG_RES3);

  always_comb begin
    status = 8'h00;
    status[FPU_STAT_BUSY]    = busy;
    status[FPU_STAT_DONE]    = done_q;
    status[FPU_STAT_TIMEOUT] = timeout_q;
    status[FPU_STAT_OVERRUN] = overrun_q;
    status[FPU_STAT_ILLEGAL] = illegal_q;
  end

  always_comb begin
    data_out = 8'h00;
    if (addr[3:2] == FPU_REG_A0[3:2])        data_out = fpu_get_byte(a_q, addr[1:0]);
    else if (addr[3:2] == FPU_REG_B0[3:2])   data_out = fpu_get_byte(b_q, addr[1:0]);
    else if (addr[3:2] == FPU_REG_RES0[3:2]) data_out = fpu_get_byte(res_q, addr[1:0]);
    else if (addr == FPU_REG_CMD)            data_out = {4'h0, op_q};
    else if (addr == FPU_REG_STATUS)         data_out = status;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    // Clears are applied first so that a coinciding set below wins.
    done_d    = done_q && !msb_rd;
    illegal_d = illegal_q && !status_rd;
    overrun_d = overrun_q && !status_rd;
    timeout_d = timeout_q && !status_rd;

    if (wr_rw_reg && busy) overrun_d = 1'b1;
    if (wr_en && !busy && (addr[3:2] == FPU_REG_A0[3:2])) a_d = fpu_set_byte(a_q, addr[1:0], data_in);
    if (wr_en && !busy && (addr[3:2] == FPU_REG_B0[3:2])) b_d = fpu_set_byte(b_q, addr[1:0], data_in);

    case (state_q)
      st_idle, st_done: begin
        if (cmd_ok) begin
          op_d    = e_fpu_operation'(data_in[3:0]);
          done_d  = 1'b0;
          state_d = st_issue;
        end else if (cmd_wr) begin
          illegal_d = 1'b1;
        end
      end
      st_issue: begin
        cnt_d   = '0;
        state_d = st_wait;
      end
      st_wait: begin
        if (fpu_done) begin
          res_d   = fpu_result;
          done_d  = 1'b1;
          state_d = st_done;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = st_idle;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: state_d = st_idle;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q   <= st_idle;
      op_q      <= op_add;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign fpu_start     = (state_q == st_issue);
  assign fpu_operation = op_q;
  assign fpu_a         = a_q;
  assign fpu_b         = b_q;
  assign irq           = done_q;

endmodule
